// File: rtl/sram_1r1w_be.sv
// sram_1r1w_be: 1R1W synchronous SRAM with per-byte write enables.
// It has a READ_LATENCY-deep read pipeline (1 or 2) and zeroes the whole
// array in hardware after reset, one word per cycle.
// Optional macro SRAM_FWD_EN: a read and a write to the same word on the
// same edge return write-first data. Without the macro, the read returns
// the old contents (read-first).

// One byte lane of the array: storage, write port, and a combinational read
// with an optional same-cycle bypass from the write port.
module sram_1r1w_be_lane #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] w_idx,
  input  logic [7:0]            w_byte,
  input  logic [DEPTH_LOG2-1:0] r_idx,
  input  logic                  fwd,
  output logic [7:0]            r_byte
);

  logic [7:0] mem [2**DEPTH_LOG2];

  // Storage has no reset; the top-level sweep clears it.
  always_ff @(posedge clock) begin
    if (we) mem[w_idx] <= w_byte;
  end

  // Return the byte being written this edge when the bypass is active.
  always_comb begin
    r_byte = fwd ? w_byte : mem[r_idx];
  end

endmodule

module sram_1r1w_be #(
  parameter  int DATA_SIZE       = 32,
  parameter  int SRAM_DEPTH_LOG2 = 5,
  parameter  int READ_LATENCY    = 1,
  localparam int BYTES           = DATA_SIZE / 8,
  localparam int BYTE_OFF        = $clog2(BYTES),
  localparam int ADDR_SIZE       = SRAM_DEPTH_LOG2 + BYTE_OFF,
  localparam int SRAM_DEPTH      = 2 ** SRAM_DEPTH_LOG2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [BYTES-1:0]     wr_be,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 init_busy,
  output logic                 req_dropped,
  output logic                 sram_full
);

  localparam logic [SRAM_DEPTH_LOG2-1:0] LAST_IDX = SRAM_DEPTH_LOG2'(SRAM_DEPTH - 1);

  typedef enum logic {SWEEP = 1'b0, READY = 1'b1} state_t;

  state_t                     state, state_nx;
  logic [SRAM_DEPTH_LOG2-1:0] idx, idx_nx;

  // Byte offset bits drop out of the shift, so the word index ignores them.
  logic [SRAM_DEPTH_LOG2-1:0] wr_word, rd_word_idx;
  assign wr_word     = SRAM_DEPTH_LOG2'(wr_addr >> BYTE_OFF);
  assign rd_word_idx = SRAM_DEPTH_LOG2'(rd_addr >> BYTE_OFF);

  // Requests that arrive during the sweep are discarded.
  logic wr_accept, rd_accept;
  assign wr_accept = wr_en & ~init_busy;
  assign rd_accept = rd_en & ~init_busy;

  assign sram_full = (wr_word == LAST_IDX);

  // Init FSM state and sweep counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= SWEEP;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Sweep advances one word per cycle. idx freezes on the last word.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      SWEEP: begin
        if (idx == LAST_IDX) state_nx = READY;
        else                 idx_nx   = idx + 1'b1;
      end
      default: ;
    endcase
  end

  // Busy flag comes straight from the state.
  always_comb begin
    init_busy = (state == SWEEP);
  end

  // Per-lane write/bypass controls. The sweep overrides the write port.
  logic [BYTES-1:0][7:0]      wr_bytes, lane_wbyte, lane_rbyte;
  logic [BYTES-1:0]           lane_we, lane_fwd;
  logic [SRAM_DEPTH_LOG2-1:0] mem_widx;

  assign wr_bytes = wr_data;
  assign mem_widx = init_busy ? idx : wr_word;

  for (genvar k = 0; k < BYTES; k++) begin : g_lane
    assign lane_we[k]    = init_busy | (wr_accept & wr_be[k]);
    assign lane_wbyte[k] = init_busy ? 8'h00 : wr_bytes[k];
`ifdef SRAM_FWD_EN
    assign lane_fwd[k]   = wr_accept & wr_be[k] & (wr_word == rd_word_idx);
`else
    assign lane_fwd[k]   = 1'b0;
`endif

    sram_1r1w_be_lane #(
      .DEPTH_LOG2 (SRAM_DEPTH_LOG2)
    ) u_lane (
      .clock  (clock),
      .we     (lane_we[k]),
      .w_idx  (mem_widx),
      .w_byte (lane_wbyte[k]),
      .r_idx  (rd_word_idx),
      .fwd    (lane_fwd[k]),
      .r_byte (lane_rbyte[k])
    );
  end

  logic [DATA_SIZE-1:0] rd_word;
  assign rd_word = lane_rbyte;

  // Read pipeline. Stage 0 is the accepted request and array output.
  // Stage s>0 is registered, and its data only loads on a valid beat.
  // rd_data therefore holds between results.
  logic [READ_LATENCY:0]                  vld_pipe;
  logic [READ_LATENCY-1:0]                vld_q;
  logic [READ_LATENCY:0][DATA_SIZE-1:0]   dat_pipe;
  logic [READ_LATENCY-1:0][DATA_SIZE-1:0] dat_q;

  assign vld_pipe = {vld_q, rd_accept};
  assign dat_pipe = {dat_q, rd_word};

  // Shift valid bits and move data forward on valid beats only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[READ_LATENCY-1:0];
      for (int s = 0; s < READ_LATENCY; s++) begin
        if (vld_pipe[s]) dat_q[s] <= dat_pipe[s];
      end
    end
  end

  assign rd_valid = vld_pipe[READ_LATENCY];
  assign rd_data  = dat_pipe[READ_LATENCY];

  // Pulse once per cycle that carried any request during the sweep.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) req_dropped <= 1'b0;
    else          req_dropped <= init_busy & (rd_en | wr_en);
  end

endmodule

// File: tb/tb_sram_1r1w_be.sv
// Directed bench for sram_1r1w_be. Two instances share all inputs:
// u_lat1 has READ_LATENCY=1 and u_lat2 has READ_LATENCY=2.
// The same-word read/write expectation follows SRAM_FWD_EN.
module tb_sram_1r1w_be;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = 4'h0;
  logic [6:0]  wr_addr = 7'h0;
  logic [31:0] wr_data = 32'h0;
  logic        rd_en = 1'b0;
  logic [6:0]  rd_addr = 7'h0;

  logic [31:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2, init_busy1, init_busy2;
  logic        req_dropped1, req_dropped2, sram_full1, sram_full2;

  int checks = 0;
  int errors = 0;

`ifdef SRAM_FWD_EN
  localparam logic [31:0] EXP_SAME = 32'h1234_5555;
`else
  localparam logic [31:0] EXP_SAME = 32'h1234_5678;
`endif

  always #5 clock = ~clock;

  sram_1r1w_be #(.DATA_SIZE(32), .SRAM_DEPTH_LOG2(5), .READ_LATENCY(1)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1),
    .req_dropped(req_dropped1), .sram_full(sram_full1));

  sram_1r1w_be #(.DATA_SIZE(32), .SRAM_DEPTH_LOG2(5), .READ_LATENCY(2)) u_lat2 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_be(wr_be),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .init_busy(init_busy2),
    .req_dropped(req_dropped2), .sram_full(sram_full2));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    step();
    wr_en = 1'b0; wr_be = 4'h0;
  endtask

  // Release reset and check the full sweep window, including dropped requests.
  task automatic run_sweep(input string tag);
    logic exp_busy, exp_drop;
    reset_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      rd_en   = (k == 5) || (k == 12);
      wr_en   = (k == 9) || (k == 12);
      wr_be   = 4'hF; wr_addr = 7'h7C; wr_data = 32'hFFFF_FFFF;
      rd_addr = 7'h0C;
      step();
      exp_busy = (k < 32);
      exp_drop = (k == 5) || (k == 9) || (k == 12);
      checks++; if (init_busy1 !== exp_busy) begin errors++; $display("FAIL %s busy1 k=%0d got=%b exp=%b", tag, k, init_busy1, exp_busy); end
      checks++; if (init_busy2 !== exp_busy) begin errors++; $display("FAIL %s busy2 k=%0d got=%b exp=%b", tag, k, init_busy2, exp_busy); end
      checks++; if (req_dropped1 !== exp_drop) begin errors++; $display("FAIL %s dropped1 k=%0d got=%b exp=%b", tag, k, req_dropped1, exp_drop); end
      checks++; if (req_dropped2 !== exp_drop) begin errors++; $display("FAIL %s dropped2 k=%0d got=%b exp=%b", tag, k, req_dropped2, exp_drop); end
      checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL %s valid1 k=%0d got=%b exp=0", tag, k, rd_valid1); end
      checks++; if (rd_valid2 !== 1'b0) begin errors++; $display("FAIL %s valid2 k=%0d got=%b exp=0", tag, k, rd_valid2); end
    end
    rd_en = 1'b0; wr_en = 1'b0; wr_be = 4'h0;
  endtask

  task automatic test_reset();
    rd_en = 1'b1; wr_en = 1'b1; wr_be = 4'hF;
    repeat (3) step();
    rd_en = 1'b0; wr_en = 1'b0; wr_be = 4'h0;
    checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL rst data1 got=%h exp=0", rd_data1); end
    checks++; if (rd_data2 !== 32'h0) begin errors++; $display("FAIL rst data2 got=%h exp=0", rd_data2); end
    checks++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin errors++; $display("FAIL rst valid got=%b%b exp=00", rd_valid1, rd_valid2); end
    checks++; if (init_busy1 !== 1'b1 || init_busy2 !== 1'b1) begin errors++; $display("FAIL rst busy got=%b%b exp=11", init_busy1, init_busy2); end
    checks++; if (req_dropped1 !== 1'b0 || req_dropped2 !== 1'b0) begin errors++; $display("FAIL rst dropped got=%b%b exp=00", req_dropped1, req_dropped2); end
    run_sweep("sweep");
  endtask

  // Read every word back-to-back right after the sweep; all must be zero.
  task automatic test_read_zero();
    for (int i = 0; i <= 32; i++) begin
      rd_en = (i < 32); rd_addr = 7'(i * 4);
      step();
      checks++; if (rd_valid1 !== (i < 32)) begin errors++; $display("FAIL zero valid1 i=%0d got=%b", i, rd_valid1); end
      checks++; if (rd_valid2 !== (i >= 1)) begin errors++; $display("FAIL zero valid2 i=%0d got=%b", i, rd_valid2); end
      checks++; if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin errors++; $display("FAIL zero data i=%0d got=%h/%h exp=0", i, rd_data1, rd_data2); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_byte_enable();
    do_write(7'h0C, 4'hF, 32'hDEAD_BEEF);
    do_write(7'h0C, 4'h5, 32'h1122_3344);
    do_write(7'h0D, 4'h0, 32'hFFFF_FFFF);
    rd_en = 1'b1; rd_addr = 7'h0E;
    step();
    rd_en = 1'b0;
    checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDE22_BE44) begin errors++; $display("FAIL be lat1 e1 got=%b/%h exp=1/de22be44", rd_valid1, rd_data1); end
    checks++; if (rd_valid2 !== 1'b0) begin errors++; $display("FAIL be lat2 e1 valid got=%b exp=0", rd_valid2); end
    step();
    checks++; if (rd_valid1 !== 1'b0 || rd_data1 !== 32'hDE22_BE44) begin errors++; $display("FAIL be lat1 hold got=%b/%h exp=0/de22be44", rd_valid1, rd_data1); end
    checks++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hDE22_BE44) begin errors++; $display("FAIL be lat2 e2 got=%b/%h exp=1/de22be44", rd_valid2, rd_data2); end
    step();
    checks++; if (rd_valid2 !== 1'b0 || rd_data2 !== 32'hDE22_BE44) begin errors++; $display("FAIL be lat2 hold got=%b/%h exp=0/de22be44", rd_valid2, rd_data2); end
  endtask

  task automatic test_same_word();
    do_write(7'h1C, 4'hF, 32'h1234_5678);
    wr_en = 1'b1; wr_addr = 7'h1C; wr_be = 4'h3; wr_data = 32'hAAAA_5555;
    rd_en = 1'b1; rd_addr = 7'h1C;
    step();
    wr_en = 1'b0; wr_be = 4'h0;
    checks++; if (rd_data1 !== EXP_SAME) begin errors++; $display("FAIL same lat1 got=%h exp=%h", rd_data1, EXP_SAME); end
    step();
    rd_en = 1'b0;
    checks++; if (rd_data2 !== EXP_SAME) begin errors++; $display("FAIL same lat2 got=%h exp=%h", rd_data2, EXP_SAME); end
    checks++; if (rd_data1 !== 32'h1234_5555) begin errors++; $display("FAIL same after lat1 got=%h exp=12345555", rd_data1); end
    step();
    checks++; if (rd_data2 !== 32'h1234_5555) begin errors++; $display("FAIL same after lat2 got=%h exp=12345555", rd_data2); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    vals[0] = 32'hA1B2_C3D4; vals[1] = 32'h0F1E_2D3C;
    vals[2] = 32'h55AA_33CC; vals[3] = 32'h89AB_CDEF;
    for (int i = 0; i < 4; i++) do_write(7'(i * 4), 4'hF, vals[i]);
    for (int i = 0; i <= 5; i++) begin
      rd_en = (i < 4); rd_addr = 7'(i * 4);
      step();
      checks++; if (rd_valid2 !== (i >= 1 && i <= 4)) begin errors++; $display("FAIL b2b valid2 i=%0d got=%b", i, rd_valid2); end
      if (i >= 1) begin
        checks++; if (rd_data2 !== vals[(i <= 4) ? i - 1 : 3]) begin errors++; $display("FAIL b2b data2 i=%0d got=%h exp=%h", i, rd_data2, vals[(i <= 4) ? i - 1 : 3]); end
      end
      if (i < 4) begin
        checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== vals[i]) begin errors++; $display("FAIL b2b lat1 i=%0d got=%b/%h exp=1/%h", i, rd_valid1, rd_data1, vals[i]); end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    rd_en = 1'b1; rd_addr = 7'h0C;
    step();
    rd_en = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (rd_data2 !== 32'h0 || rd_valid2 !== 1'b0) begin errors++; $display("FAIL flight lat2 got=%b/%h exp=0/0", rd_valid2, rd_data2); end
    checks++; if (rd_data1 !== 32'h0 || init_busy1 !== 1'b1) begin errors++; $display("FAIL flight lat1 got=%h busy=%b exp=0/1", rd_data1, init_busy1); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin errors++; $display("FAIL flight valid k=%0d got=%b%b exp=00", k, rd_valid1, rd_valid2); end
    end
    run_sweep("resweep");
    rd_en = 1'b1; rd_addr = 7'h0C;
    step();
    rd_en = 1'b0;
    checks++; if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin errors++; $display("FAIL resweep w3 lat1 got=%b/%h exp=1/0", rd_valid1, rd_data1); end
    step();
    checks++; if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin errors++; $display("FAIL resweep w3 lat2 got=%b/%h exp=1/0", rd_valid2, rd_data2); end
  endtask

  task automatic test_sram_full();
    wr_addr = 7'h7C; #1;
    checks++; if (sram_full1 !== 1'b1 || sram_full2 !== 1'b1) begin errors++; $display("FAIL full 7c got=%b%b exp=11", sram_full1, sram_full2); end
    wr_addr = 7'h78; #1;
    checks++; if (sram_full1 !== 1'b0) begin errors++; $display("FAIL full 78 got=%b exp=0", sram_full1); end
    wr_addr = 7'h7F; #1;
    checks++; if (sram_full1 !== 1'b1) begin errors++; $display("FAIL full 7f got=%b exp=1", sram_full1); end
    wr_addr = 7'h03; #1;
    checks++; if (sram_full1 !== 1'b0) begin errors++; $display("FAIL full 03 got=%b exp=0", sram_full1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_zero();
    test_byte_enable();
    test_same_word();
    test_back_to_back();
    test_reset_in_flight();
    test_sram_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
